// File: rtl/mini16sc_pkg.sv
// Shared definitions for the mini16sc CPU and its program loader.
package mini16sc_pkg;

  // Instruction word width and instruction address width shared with the CPU.
  localparam int WIDTH_I_DEF = 16;
  localparam int DEPTH_I_DEF = 8;

  // Frame start marker for the loader byte stream.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CSUM    = 3'd5,
    ST_ERR     = 3'd6
  } loader_state_t;

endpackage

// File: rtl/mini16sc_loader.sv
// Program loader for the mini16sc core: parses a framed byte stream
// (SYNC, LEN_LO, LEN_HI, N x (DATA_LO, DATA_HI), CSUM), writes the words
// into the instruction RAM and holds the CPU in soft reset until a frame
// with a good checksum has been committed.
//
// Handshake: a byte is transferred on every clock edge where
// rx_valid && rx_ready; rx_ready is high in every state from the first
// clock after reset release, so the loader sustains one byte per clock.
module mini16sc_loader
  import mini16sc_pkg::*;
#(
  parameter int         WIDTH_I   = WIDTH_I_DEF,
  parameter int         DEPTH_I   = DEPTH_I_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter bit         BOOT_HOLD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [DEPTH_I-1:0] mem_i_w_addr,
  output logic [WIDTH_I-1:0] mem_i_w_data,
  output logic               mem_i_we,
  output logic               soft_reset,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_error,
  output loader_state_t      dbg_state
);

  // Largest legal word count: a frame may fill the whole RAM.
  localparam logic [16:0] MAX_N = 17'(1) << DEPTH_I;

  // Registered state.
  loader_state_t      r_state;
  logic               r_rx_ready;
  logic [15:0]        r_count;
  logic [DEPTH_I:0]   r_idx;
  logic [7:0]         r_csum;
  logic [7:0]         r_lo;
  logic               r_we;
  logic [DEPTH_I-1:0] r_addr;
  logic [WIDTH_I-1:0] r_data;
  logic               r_soft_reset;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  // Next-state values.
  loader_state_t      w_state_nxt;
  logic [15:0]        w_count_nxt;
  logic [DEPTH_I:0]   w_idx_nxt;
  logic [7:0]         w_csum_nxt;
  logic [7:0]         w_lo_nxt;
  logic               w_we_nxt;
  logic [DEPTH_I-1:0] w_addr_nxt;
  logic [WIDTH_I-1:0] w_data_nxt;
  logic               w_soft_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;

  // Helpers.
  logic               w_accept;
  logic               w_is_sync;
  logic [15:0]        w_len;
  logic [DEPTH_I:0]   w_idx_inc;

  assign w_accept  = rx_valid && r_rx_ready;
  assign w_is_sync = (rx_data == SYNC_BYTE);
  assign w_len     = {rx_data, r_count[7:0]};
  assign w_idx_inc = r_idx + (DEPTH_I+1)'(1);

  // State and output registers; everything returns to reset values at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rx_ready   <= 1'b0;
      r_count      <= '0;
      r_idx        <= '0;
      r_csum       <= '0;
      r_lo         <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_soft_reset <= BOOT_HOLD;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_ready   <= 1'b1;
      r_count      <= w_count_nxt;
      r_idx        <= w_idx_nxt;
      r_csum       <= w_csum_nxt;
      r_lo         <= w_lo_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_soft_reset <= w_soft_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // Frame parser: next state plus next values of every registered output.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_csum_nxt  = r_csum;
    w_lo_nxt    = r_lo;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_soft_nxt  = r_soft_reset;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;

    if (w_accept) begin
      case (r_state)
        // IDLE and ERR both wait for a sync byte; a new frame clears the error.
        ST_IDLE, ST_ERR: begin
          if (w_is_sync) begin
            w_state_nxt = ST_LEN_LO;
            w_csum_nxt  = 8'h00;
            w_busy_nxt  = 1'b1;
            w_soft_nxt  = 1'b1;
            w_error_nxt = 1'b0;
          end
        end

        ST_LEN_LO: begin
          w_count_nxt = {r_count[15:8], rx_data};
          w_csum_nxt  = r_csum ^ rx_data;
          w_state_nxt = ST_LEN_HI;
        end

        ST_LEN_HI: begin
          w_count_nxt = w_len;
          w_csum_nxt  = r_csum ^ rx_data;
          w_idx_nxt   = '0;
          if ({1'b0, w_len} > MAX_N) begin
            // Would overrun the RAM: reject before any write happens.
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else if (w_len == 16'h0000) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_DATA_LO;
          end
        end

        ST_DATA_LO: begin
          w_lo_nxt    = rx_data;
          w_csum_nxt  = r_csum ^ rx_data;
          w_state_nxt = ST_DATA_HI;
        end

        // The completed word is presented to the RAM on the following cycle.
        ST_DATA_HI: begin
          w_csum_nxt  = r_csum ^ rx_data;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_idx[DEPTH_I-1:0];
          w_data_nxt  = WIDTH_I'({rx_data, r_lo});
          w_idx_nxt   = w_idx_inc;
          if (16'(w_idx_inc) == r_count) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_DATA_LO;
          end
        end

        // Only a matching checksum lets the CPU out of soft reset.
        ST_CSUM: begin
          w_busy_nxt = 1'b0;
          if (rx_data == r_csum) begin
            w_state_nxt = ST_IDLE;
            w_soft_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign rx_ready     = r_rx_ready;
  assign mem_i_we     = r_we;
  assign mem_i_w_addr = r_addr;
  assign mem_i_w_data = r_data;
  assign soft_reset   = r_soft_reset;
  assign load_busy    = r_busy;
  assign load_done    = r_done;
  assign load_error   = r_error;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mini16sc_loader.sv
// Bench for mini16sc_loader: frame-level model of the loader protocol with an
// expected-write queue, a per-cycle compare process and directed frames.
module tb_mini16sc_loader;
  import mini16sc_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  mem_i_w_addr;
  logic [15:0] mem_i_w_data;
  logic        mem_i_we;
  logic        soft_reset;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  loader_state_t dbg_state;

  mini16sc_loader #(
    .WIDTH_I(16),
    .DEPTH_I(8),
    .SYNC_BYTE(8'hA5),
    .BOOT_HOLD(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_i_w_addr(mem_i_w_addr),
    .mem_i_w_data(mem_i_w_data),
    .mem_i_we(mem_i_we),
    .soft_reset(soft_reset),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_error(load_error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  logic [15:0] model_ram [0:255];
  logic [15:0] ram_dut   [0:255];
  logic [7:0]  fr[$];
  logic [15:0] wds [0:255];
  int          n_checks;
  int          n_fail;
  int          done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: every RAM write must be the next expected one.
  always @(negedge clk) begin
    logic [23:0] exp_w;
    if (!reset) begin
      if (mem_i_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_i_w_addr, mem_i_w_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("ram_write", {8'h00, mem_i_w_addr, mem_i_w_data}, {8'h00, exp_w});
        end
        ram_dut[mem_i_w_addr] = mem_i_w_data;
      end
      if (load_done) done_seen++;
      if (load_busy) chk("soft_reset_held_in_frame", {31'd0, soft_reset}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    int waitc;
    if (gap) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    waitc = 0;
    while (!rx_ready && waitc < 8) begin
      @(negedge clk);
      waitc++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Build a frame: header with length n, nw words from wds[], checksum (optionally corrupted).
  task automatic build(input logic [15:0] n, input int nw, input bit bad);
    logic [7:0] cs;
    fr = {};
    fr.push_back(8'hA5);
    fr.push_back(n[7:0]);
    fr.push_back(n[15:8]);
    cs = n[7:0] ^ n[15:8];
    for (int i = 0; i < nw; i++) begin
      fr.push_back(wds[i][7:0]);
      fr.push_back(wds[i][15:8]);
      cs = cs ^ wds[i][7:0] ^ wds[i][15:8];
    end
    fr.push_back(bad ? ~cs : cs);
  endtask

  // Model the frame's effect, send it, then check the end-of-frame status.
  task automatic run_frame(input bit gap);
    int n;
    logic [7:0] cs;
    bit ok;
    bit err;
    int d0;
    n = int'({fr[2], fr[1]});
    ok = 1'b0;
    err = 1'b1;
    if (n <= 256) begin
      cs = 8'h00;
      for (int i = 1; i <= 2 + 2 * n; i++) cs = cs ^ fr[i];
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({i[7:0], fr[4 + 2 * i], fr[3 + 2 * i]});
        model_ram[i] = {fr[4 + 2 * i], fr[3 + 2 * i]};
      end
      ok  = (fr[3 + 2 * n] == cs);
      err = !ok;
    end
    d0 = done_seen;
    for (int k = 0; k < fr.size(); k++) begin
      send_byte(fr[k], gap && (k > 0));
      if (k == 0) begin
        chk("busy_on_sync", {31'd0, load_busy}, 32'd1);
        chk("error_clear_on_sync", {31'd0, load_error}, 32'd0);
        chk("soft_reset_on_sync", {31'd0, soft_reset}, 32'd1);
      end
    end
    chk("done_after_csum", {31'd0, load_done}, {31'd0, ok});
    chk("soft_reset_after_frame", {31'd0, soft_reset}, {31'd0, !ok});
    chk("error_after_frame", {31'd0, load_error}, {31'd0, err});
    chk("busy_after_frame", {31'd0, load_busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, load_done}, 32'd0);
    chk("done_count", done_seen - d0, {31'd0, ok});
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd0);
    chk({tag, "_we"},         {31'd0, mem_i_we},   32'd0);
    chk({tag, "_addr"},       {24'd0, mem_i_w_addr}, 32'd0);
    chk({tag, "_data"},       {16'd0, mem_i_w_data}, 32'd0);
    chk({tag, "_soft_reset"}, {31'd0, soft_reset}, 32'd1);
    chk({tag, "_busy"},       {31'd0, load_busy},  32'd0);
    chk({tag, "_done"},       {31'd0, load_done},  32'd0);
    chk({tag, "_error"},      {31'd0, load_error}, 32'd0);
    chk({tag, "_state"},      {29'd0, dbg_state},  32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int mism;
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    for (int i = 0; i < 256; i++) begin
      model_ram[i] = 16'h0000;
      ram_dut[i]   = 16'h0000;
    end

    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rx_ready_before_first_clk", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rx_ready_after_first_clk", {31'd0, rx_ready}, 32'd1);

    // Minimal frame N=2.
    wds[0] = 16'h1234;
    wds[1] = 16'hABCD;
    build(16'd2, 2, 1'b0);
    chk("csum_literal", {24'd0, fr[7]}, 32'h42);
    run_frame(1'b0);
    chk("ram0_literal", {16'd0, ram_dut[0]}, 32'h1234);
    chk("ram1_literal", {16'd0, ram_dut[1]}, 32'hABCD);

    // Same frame, bad checksum.
    build(16'd2, 2, 1'b1);
    chk("bad_csum_literal", {24'd0, fr[7]}, 32'hBD);
    run_frame(1'b0);

    // Recovery frame, N=3, including a sync value as data.
    wds[0] = 16'hA5A5;
    wds[1] = 16'h0F0F;
    wds[2] = 16'h5A00;
    build(16'd3, 3, 1'b0);
    run_frame(1'b0);

    // Empty frame.
    build(16'd0, 0, 1'b0);
    chk("empty_frame_len", fr.size(), 32'd4);
    run_frame(1'b0);

    // Oversize length 257.
    build(16'h0101, 0, 1'b0);
    run_frame(1'b0);

    // Full RAM, 256 words.
    for (int i = 0; i < 256; i++) wds[i] = 16'($urandom);
    build(16'd256, 256, 1'b0);
    run_frame(1'b0);

    // Same N=3 frame without and then with random gaps.
    wds[0] = 16'h1111;
    wds[1] = 16'h2222;
    wds[2] = 16'h3333;
    build(16'd3, 3, 1'b0);
    run_frame(1'b0);
    run_frame(1'b1);
    chk("gapped_word2_literal", {16'd0, ram_dut[2]}, 32'h3333);

    // Reset after the DATA_LO of word 1.
    wds[0] = 16'hCAFE;
    wds[1] = 16'hBEEF;
    wds[2] = 16'hF00D;
    build(16'd3, 3, 1'b0);
    exp_q.push_back({8'h00, 16'hCAFE});
    model_ram[0] = 16'hCAFE;
    for (int k = 0; k < 6; k++) send_byte(fr[k], 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_writes_drained", exp_q.size(), 32'd0);

    // Frame after the reset loads correctly.
    wds[0] = 16'h0102;
    wds[1] = 16'h0304;
    build(16'd2, 2, 1'b0);
    run_frame(1'b0);
    chk("post_reset_word0", {16'd0, ram_dut[0]}, 32'h0102);

    // Whole RAM image against the model.
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram_dut[i] !== model_ram[i]) mism++;
    chk("ram_image", mism, 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
